ps2_key_capture: RTL and testbench

PS2_KEY_CAPTURE -- requirements
Module: ps2_key_capture

---
 rtl/ps2_key_capture.sv | 87 ++++++++
 tb/tb_ps2_key_capture.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ps2_key_capture.sv
// ps2_key_capture: receives PS/2 keyboard frames, tracks the held key's scancode
// and keeps a two-digit BCD count of distinct key presses.
module ps2_key_capture #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] code_lo,
    output logic [3:0] code_hi,
    output logic [3:0] cnt_lo,
    output logic [3:0] cnt_hi,
    output logic       key_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BREAK = 1'b1;
    logic [2:0]    clk_s, dat_s;
    logic [3:0]    bcnt;
    logic [9:0]    sh;
    logic [TW-1:0] tcnt;
    logic          byte_vld;
    logic [7:0]    byte_r, code;
    logic [0:0]    state;
    logic          fall, last, ok, hit;
    assign fall    = clk_s[2] & ~clk_s[1];
    assign last    = fall && bcnt == 4'd10;
    // sh[0] is the start bit, sh[8:1] the data, sh[9] parity; stop is the bit arriving now
    assign ok      = ~sh[0] & dat_s[1] & (^sh[9:1]);
    assign hit     = key_valid && byte_r == code;
    assign code_hi = code[7:4];
    assign code_lo = code[3:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s     <= '1;
            dat_s     <= '1;
            bcnt      <= '0;
            sh        <= '0;
            tcnt      <= '0;
            byte_vld  <= 1'b0;
            byte_r    <= '0;
            frame_err <= 1'b0;
        end else begin
            clk_s     <= {clk_s[1:0], ps2_clk};
            dat_s     <= {dat_s[1:0], ps2_data};
            byte_vld  <= last && ok;
            frame_err <= last && !ok;
            if (last) byte_r <= sh[8:1];
            if (fall) begin
                sh   <= {dat_s[1], sh[9:1]};
                bcnt <= last ? 4'd0 : bcnt + 4'd1;
                tcnt <= '0;
            end else if (bcnt != 4'd0) begin
                // a stalled partial frame is dropped silently
                if (tcnt == TW'(TIMEOUT - 1)) begin
                    bcnt <= '0;
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            code      <= '0;
            key_valid <= 1'b0;
            cnt_lo    <= '0;
            cnt_hi    <= '0;
        end else if (byte_vld) begin
            if (state == BREAK) begin
                state <= IDLE;
                if (hit) key_valid <= 1'b0;
            end else if (byte_r == 8'hF0) begin
                state <= BREAK;
            end else if (byte_r != 8'hE0 && !hit) begin
                code      <= byte_r;
                key_valid <= 1'b1;
                cnt_lo    <= cnt_lo == 4'd9 ? 4'd0 : cnt_lo + 4'd1;
                if (cnt_lo == 4'd9) cnt_hi <= cnt_hi == 4'd9 ? 4'd0 : cnt_hi + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_capture.sv
// tb_ps2_key_capture: directed PS/2 frames; expected output changes go into a
// queue that a monitor thread pops whenever the observed outputs change.
module tb_ps2_key_capture;
    localparam int TO = 64;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [3:0] code_lo, code_hi, cnt_lo, cnt_hi;
    logic key_valid, frame_err;
    int checks = 0, errors = 0;
    logic [21:0] q[$];
    ps2_key_capture #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code_lo(code_lo), .code_hi(code_hi), .cnt_lo(cnt_lo), .cnt_hi(cnt_hi),
        .key_valid(key_valid), .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    function automatic logic [21:0] ev(input logic err, input logic kv, input logic [7:0] c, input int n);
        return {err, kv, c, 4'(n / 10), 4'(n % 10)};
    endfunction
    function automatic logic [21:0] obs();
        return {frame_err, key_valid, code_hi, code_lo, cnt_hi, cnt_lo};
    endfunction
    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask
    task automatic send(input logic [7:0] b, input logic perr = 1'b0, input logic st = 1'b0,
                        input logic sp = 1'b1, input int nbits = 11);
        logic [10:0] bits;
        bits = {sp, ~^b ^ perr, b, st};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(4);
            ps2_clk = 1'b0;
            cyc(4);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(8);
    endtask
    initial begin
        fork
            begin
                logic [21:0] prev, cur, exp;
                logic err_prev;
                prev = '0;
                err_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    cur = obs();
                    if (rst) begin
                        prev = cur;
                        err_prev = 1'b0;
                    end else begin
                        if (err_prev) check("err_width", {21'd0, frame_err}, 22'd0);
                        if (cur !== prev) begin
                            if (q.size() == 0) check("unexpected_change", cur, prev);
                            else begin
                                exp = q.pop_front();
                                check("output_event", cur, exp);
                            end
                        end
                        err_prev = frame_err;
                        prev = cur;
                    end
                end
            end
        join_none
        cyc(3);
        check("reset_state", obs(), '0);
        rst = 1'b0;
        cyc(4);
        q.push_back(ev(0, 1, 8'h1C, 1));
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        q.push_back(ev(0, 0, 8'h1C, 1));
        send(8'h1C);
        q.push_back(ev(1, 0, 8'h1C, 1));
        q.push_back(ev(0, 0, 8'h1C, 1));
        send(8'h1C, 1'b1);
        q.push_back(ev(1, 0, 8'h1C, 1));
        q.push_back(ev(0, 0, 8'h1C, 1));
        send(8'h32, 1'b0, 1'b0, 1'b0);
        q.push_back(ev(1, 0, 8'h1C, 1));
        q.push_back(ev(0, 0, 8'h1C, 1));
        send(8'h32, 1'b0, 1'b1, 1'b1);
        send(8'hE0);
        send(8'h32, 1'b0, 1'b0, 1'b1, 5);
        cyc(TO + 20);
        q.push_back(ev(0, 1, 8'h32, 2));
        send(8'h32);
        q.push_back(ev(0, 1, 8'h1C, 3));
        send(8'h1C);
        send(8'hF0);
        send(8'h32);
        send(8'hF0);
        q.push_back(ev(0, 0, 8'h1C, 3));
        send(8'h1C);
        q.push_back(ev(0, 1, 8'h32, 4));
        send(8'h32);
        check("pre_reset_state", obs(), ev(0, 1, 8'h32, 4));
        send(8'h1C, 1'b0, 1'b0, 1'b1, 6);
        rst = 1'b1;
        cyc(2);
        @(negedge clk);
        check("midframe_reset", obs(), '0);
        rst = 1'b0;
        cyc(4);
        q.push_back(ev(0, 1, 8'h1C, 1));
        send(8'h1C);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(4);
        for (int i = 0; i < 100; i++) begin
            logic [7:0] k;
            k = (i % 2 == 0) ? 8'h1C : 8'h32;
            q.push_back(ev(0, 1, k, (i + 1) % 100));
            send(k);
            send(8'hF0);
            q.push_back(ev(0, 0, k, (i + 1) % 100));
            send(k);
        end
        cyc(20);
        check("final_state", obs(), ev(0, 0, 8'h32, 0));
        check("queue_drained", 22'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
